// File: rtl/mem_bus_ctrl_if.sv
// Bus bundle between the core memory port, the controller and the memory targets.
// The slave view is the controller; the master view is the core/target side.
interface mem_bus_ctrl_if #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int N_REGIONS = 2
);
    logic                        req_valid;
    logic                        req_ready;
    logic                        req_we;
    logic [ADDR_W-1:0]           req_addr;
    logic [DATA_W-1:0]           req_wdata;
    logic                        resp_valid;
    logic                        resp_ready;
    logic [DATA_W-1:0]           resp_rdata;
    logic                        resp_err;
    logic [N_REGIONS-1:0]        mem_sel;
    logic [N_REGIONS-1:0]        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [N_REGIONS*DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_sel, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_sel, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller: decodes one core request into a base/mask region table,
// runs a per-region wait-state access and returns a registered response.
module mem_bus_ctrl #(
    parameter int                           ADDR_W      = 64,
    parameter int                           DATA_W      = 64,
    parameter int                           N_REGIONS   = 2,
    parameter logic [N_REGIONS*ADDR_W-1:0]  REGION_BASE = {64'h2000, 64'h0},
    parameter logic [N_REGIONS*ADDR_W-1:0]  REGION_MASK = {64'hFFFF_FFFF_FFFF_E000,
                                                           64'hFFFF_FFFF_FFFF_E000},
    parameter logic [N_REGIONS*4-1:0]       REGION_WAIT = {4'd2, 4'd0}
) (
    input  logic           clk,
    input  logic           reset,
    mem_bus_ctrl_if.slave  bus
);

    localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t               state_r,      state_nxt_s;
    logic [3:0]           cnt_r,        cnt_nxt_s;
    logic                 we_r,         we_nxt_s;
    logic [IDX_W-1:0]     idx_r,        idx_nxt_s;
    logic                 req_ready_r,  req_ready_nxt_s;
    logic                 resp_valid_r, resp_valid_nxt_s;
    logic                 resp_err_r,   resp_err_nxt_s;
    logic [DATA_W-1:0]    resp_rdata_r, resp_rdata_nxt_s;
    logic [N_REGIONS-1:0] mem_sel_r,    mem_sel_nxt_s;
    logic [N_REGIONS-1:0] mem_we_r,     mem_we_nxt_s;
    logic [ADDR_W-1:0]    mem_addr_r,   mem_addr_nxt_s;
    logic [DATA_W-1:0]    mem_wdata_r,  mem_wdata_nxt_s;

    logic                 hit_s;
    logic [IDX_W-1:0]     hit_idx_s;
    logic [N_REGIONS-1:0] hit_oh_s;
    logic [ADDR_W-1:0]    hit_off_s;
    logic [3:0]           hit_wait_s;
    logic [DATA_W-1:0]    sel_rdata_s;
    logic                 accept_s;

    // Parallel region compare; scanning downward lets the lowest index win.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = {IDX_W{1'b0}};
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if ((bus.req_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // Per-hit derived values: one-hot select, in-region offset and wait count.
    always_comb begin
        hit_oh_s    = N_REGIONS'(1'b1) << hit_idx_s;
        hit_off_s   = bus.req_addr & ~REGION_MASK[int'(hit_idx_s)*ADDR_W +: ADDR_W];
        hit_wait_s  = REGION_WAIT[int'(hit_idx_s)*4 +: 4];
        sel_rdata_s = bus.mem_rdata[int'(idx_r)*DATA_W +: DATA_W];
        accept_s    = bus.req_valid && req_ready_r;
    end

    // Next-state and next-output logic; every output is registered one edge later.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        we_nxt_s         = we_r;
        idx_nxt_s        = idx_r;
        req_ready_nxt_s  = req_ready_r;
        resp_valid_nxt_s = resp_valid_r;
        resp_err_nxt_s   = resp_err_r;
        resp_rdata_nxt_s = resp_rdata_r;
        mem_sel_nxt_s    = mem_sel_r;
        mem_we_nxt_s     = {N_REGIONS{1'b0}};
        mem_addr_nxt_s   = mem_addr_r;
        mem_wdata_nxt_s  = mem_wdata_r;
        case (state_r)
            IDLE: begin
                req_ready_nxt_s = 1'b1;
                if (accept_s) begin
                    we_nxt_s        = bus.req_we;
                    req_ready_nxt_s = 1'b0;
                    if (hit_s) begin
                        idx_nxt_s       = hit_idx_s;
                        cnt_nxt_s       = hit_wait_s;
                        mem_sel_nxt_s   = hit_oh_s;
                        mem_addr_nxt_s  = hit_off_s;
                        mem_wdata_nxt_s = bus.req_wdata;
                        // A zero-wait write strobes in the very first access cycle.
                        if (bus.req_we && (hit_wait_s == 4'd0)) begin
                            mem_we_nxt_s = hit_oh_s;
                        end else begin
                            mem_we_nxt_s = {N_REGIONS{1'b0}};
                        end
                        state_nxt_s = ACCESS;
                    end else begin
                        resp_err_nxt_s   = 1'b1;
                        resp_rdata_nxt_s = {DATA_W{1'b0}};
                        resp_valid_nxt_s = 1'b1;
                        state_nxt_s      = RESP;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                req_ready_nxt_s = 1'b0;
                if (cnt_r != 4'd0) begin
                    cnt_nxt_s = cnt_r - 4'd1;
                    if (we_r && (cnt_r == 4'd1)) begin
                        mem_we_nxt_s = mem_sel_r;
                    end else begin
                        mem_we_nxt_s = {N_REGIONS{1'b0}};
                    end
                end else begin
                    mem_sel_nxt_s    = {N_REGIONS{1'b0}};
                    resp_valid_nxt_s = 1'b1;
                    resp_err_nxt_s   = 1'b0;
                    if (we_r) begin
                        resp_rdata_nxt_s = {DATA_W{1'b0}};
                    end else begin
                        resp_rdata_nxt_s = sel_rdata_s;
                    end
                    state_nxt_s = RESP;
                end
            end
            RESP: begin
                mem_sel_nxt_s = {N_REGIONS{1'b0}};
                if (bus.resp_ready) begin
                    resp_valid_nxt_s = 1'b0;
                    req_ready_nxt_s  = 1'b1;
                    state_nxt_s      = IDLE;
                end else begin
                    resp_valid_nxt_s = 1'b1;
                    req_ready_nxt_s  = 1'b0;
                end
            end
            default: begin
                state_nxt_s      = IDLE;
                cnt_nxt_s        = 4'd0;
                req_ready_nxt_s  = 1'b1;
                resp_valid_nxt_s = 1'b0;
                mem_sel_nxt_s    = {N_REGIONS{1'b0}};
            end
        endcase
    end

    // State and output registers; reset drops any in-flight access without a strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            we_r         <= 1'b0;
            idx_r        <= {IDX_W{1'b0}};
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= {DATA_W{1'b0}};
            mem_sel_r    <= {N_REGIONS{1'b0}};
            mem_we_r     <= {N_REGIONS{1'b0}};
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            we_r         <= we_nxt_s;
            idx_r        <= idx_nxt_s;
            req_ready_r  <= req_ready_nxt_s;
            resp_valid_r <= resp_valid_nxt_s;
            resp_err_r   <= resp_err_nxt_s;
            resp_rdata_r <= resp_rdata_nxt_s;
            mem_sel_r    <= mem_sel_nxt_s;
            mem_we_r     <= mem_we_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_wdata_r  <= mem_wdata_nxt_s;
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.mem_sel    = mem_sel_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: a default-configured instance plus an
// all-overlapping instance for the priority case, both fed the same stimulus.
module tb_mem_bus_ctrl;

    localparam int          AW  = 64;
    localparam int          DW  = 64;
    localparam int          NR  = 2;
    localparam logic [63:0] RD0 = 64'h0000_0000_0000_00AB;
    localparam logic [63:0] RD1 = 64'h1234_5678_9ABC_DEF0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic        resp_ready = 1'b0;
    logic [63:0] req_addr = 64'h0;
    logic [63:0] req_wdata = 64'h0;
    logic        use2 = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    // Reference region tables: [config][region]
    logic [63:0] m_base [2][2] = '{'{64'h0, 64'h2000}, '{64'h0, 64'h0}};
    logic [63:0] m_mask [2][2] = '{'{64'hFFFF_FFFF_FFFF_E000, 64'hFFFF_FFFF_FFFF_E000},
                                   '{64'h0, 64'h0}};
    int          m_wait [2][2] = '{'{0, 2}, '{0, 1}};

    always #5 clk = ~clk;

    mem_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .N_REGIONS(NR)) bus1 ();
    mem_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .N_REGIONS(NR)) bus2 ();

    assign bus1.req_valid  = req_valid;
    assign bus1.req_we     = req_we;
    assign bus1.req_addr   = req_addr;
    assign bus1.req_wdata  = req_wdata;
    assign bus1.resp_ready = resp_ready;
    assign bus1.mem_rdata  = {RD1, RD0};
    assign bus2.req_valid  = req_valid;
    assign bus2.req_we     = req_we;
    assign bus2.req_addr   = req_addr;
    assign bus2.req_wdata  = req_wdata;
    assign bus2.resp_ready = resp_ready;
    assign bus2.mem_rdata  = {RD1, RD0};

    mem_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .N_REGIONS(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    mem_bus_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .N_REGIONS(NR),
        .REGION_BASE(128'h0), .REGION_MASK(128'h0), .REGION_WAIT(8'h10)
    ) dut_prio (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    wire        obs_req_ready  = use2 ? bus2.req_ready  : bus1.req_ready;
    wire        obs_resp_valid = use2 ? bus2.resp_valid : bus1.resp_valid;
    wire        obs_resp_err   = use2 ? bus2.resp_err   : bus1.resp_err;
    wire [63:0] obs_resp_rdata = use2 ? bus2.resp_rdata : bus1.resp_rdata;
    wire [1:0]  obs_mem_sel    = use2 ? bus2.mem_sel    : bus1.mem_sel;
    wire [1:0]  obs_mem_we     = use2 ? bus2.mem_we     : bus1.mem_we;
    wire [63:0] obs_mem_addr   = use2 ? bus2.mem_addr   : bus1.mem_addr;
    wire [63:0] obs_mem_wdata  = use2 ? bus2.mem_wdata  : bus1.mem_wdata;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int model_region(input int cfg, input logic [63:0] a);
        for (int i = 0; i < 2; i++) begin
            if ((a & m_mask[cfg][i]) == m_base[cfg][i]) return i;
        end
        return -1;
    endfunction

    // One full transaction: drive, observe the access phase, hold, handshake.
    task automatic do_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          input int hold);
        int          cfg, r, waits, lat, sel_cyc, we_cyc, we_at, bad, bad_hold;
        logic [1:0]  oh;
        logic [63:0] off, snap;
        exp_t        e, got;
        cfg     = use2 ? 1 : 0;
        r       = model_region(cfg, addr);
        waits   = (r < 0) ? 0 : m_wait[cfg][r];
        oh      = (r == 1) ? 2'b10 : 2'b01;
        off     = (r < 0) ? 64'h0 : (addr & ~m_mask[cfg][r]);
        e.err   = (r < 0);
        e.rdata = (we || r < 0) ? 64'h0 : ((r == 0) ? RD0 : RD1);
        sb.push_back(e);

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        for (int k = 0; k < 20 && !obs_req_ready; k++) @(negedge clk);
        check("accept_ready", obs_req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0;
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};

        lat = 0; sel_cyc = 0; we_cyc = 0; we_at = 0; bad = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (obs_resp_valid) begin
                lat = k;
                break;
            end
            if (obs_mem_sel != 2'b00) begin
                sel_cyc++;
                if (obs_mem_sel != oh || obs_mem_addr != off || (we && obs_mem_wdata != wdata)) bad++;
            end
            if (obs_mem_we != 2'b00) begin
                we_cyc++;
                we_at = k;
                if (obs_mem_we != oh) bad++;
            end
            if (obs_req_ready) bad++;
        end
        check("resp_latency", lat, (r < 0) ? 1 : waits + 2);
        check("sel_cycles", sel_cyc, (r < 0) ? 0 : waits + 1);
        check("we_pulses", we_cyc, (we && r >= 0) ? 1 : 0);
        check("we_position", we_at, (we && r >= 0) ? waits + 1 : 0);
        check("access_signals", bad, 0);

        snap = obs_resp_rdata;
        bad_hold = 0;
        if (hold > 0) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h10;
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!obs_resp_valid || obs_resp_rdata !== snap || obs_req_ready || obs_mem_sel != 2'b00)
                bad_hold++;
        end
        req_valid = 1'b0;
        check("resp_hold", bad_hold, 0);

        got.rdata = obs_resp_rdata;
        got.err   = obs_resp_err;
        e = sb.pop_front();
        check("resp_rdata", got.rdata, e.rdata);
        check("resp_err", got.err, e.err);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("resp_cleared", obs_resp_valid, 1'b0);
        check("ready_after", obs_req_ready, 1'b1);
        check("rdata_kept", obs_resp_rdata, e.rdata);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, bus1.req_ready, 1'b1);
        check({tag, "_resp_valid"}, bus1.resp_valid, 1'b0);
        check({tag, "_resp_err"}, bus1.resp_err, 1'b0);
        check({tag, "_resp_rdata"}, bus1.resp_rdata, 64'h0);
        check({tag, "_mem_sel"}, bus1.mem_sel, 2'b00);
        check({tag, "_mem_we"}, bus1.mem_we, 2'b00);
        check({tag, "_mem_addr"}, bus1.mem_addr, 64'h0);
        check({tag, "_mem_wdata"}, bus1.mem_wdata, 64'h0);
    endtask

    initial begin
        int stray;
        int pick;
        logic [63:0] a;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;
        @(negedge clk);

        do_req(1'b0, 64'h10, 64'h0, 0);
        do_req(1'b1, 64'h2008, 64'h55, 0);
        do_req(1'b0, 64'h8000, 64'h0, 0);
        do_req(1'b0, 64'h2000, 64'h0, 5);

        for (int n = 0; n < 8; n++) begin
            pick = $urandom_range(0, 2);
            case (pick)
                0:       a = {51'h0, 13'($urandom)};
                1:       a = 64'h2000 + {51'h0, 13'($urandom)};
                default: a = 64'h4000 + {32'h0, $urandom};
            endcase
            do_req(1'($urandom), a, {$urandom, $urandom}, $urandom_range(0, 2));
        end

        // Leave nonzero response state behind, then abort a write mid-access.
        do_req(1'b0, 64'h2010, 64'h0, 0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h2000; req_wdata = 64'hDEAD_BEEF;
        check("rst_accept_ready", bus1.req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0;
        stray = 0;
        @(negedge clk);
        check("rst_sel_access1", bus1.mem_sel, 2'b10);
        if (bus1.mem_we != 2'b00) stray++;
        @(negedge clk);
        if (bus1.mem_we != 2'b00) stray++;
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        repeat (2) begin
            @(negedge clk);
            if (bus1.mem_we != 2'b00 || bus1.resp_valid) stray++;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus1.mem_we != 2'b00 || bus1.resp_valid || bus1.mem_sel != 2'b00) stray++;
        end
        check("rst_no_activity", stray, 0);
        check("rst_ready_after", bus1.req_ready, 1'b1);

        use2 = 1'b1;
        do_req(1'b0, 64'h100, 64'h0, 0);
        do_req(1'b1, 64'h2008, 64'h77, 0);
        use2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
